// File: rtl/link_write_arbiter.sv
// link_write_arbiter
// Picks one pending register-file write from up to NREQ clients and hands it
// to the serial transmitter as a single-cycle send, then holds off for the
// rest of the frame time before the next grant.
//
// Build option: define LINK_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer). Left undefined, arbitration is round-robin.

module link_write_arbiter #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_addr,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              send,
    output logic [1:0]        taddr,
    output logic [3:0]        tdata,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic [7:0]        frames_sent
);

    // The gap counter is loaded with GAP_CYCLES-2 in SEND; together with the
    // SEND cycle and the IDLE decision cycle this makes one send-to-send loop
    // exactly GAP_CYCLES long.
    localparam int               CNT_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] gap_cnt;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [1:0]       win_addr;
    logic [3:0]       win_data;

    // Reduce an arbitrary client number modulo NREQ into a 3-bit index.
    function automatic logic [2:0] wrap_idx(input int v);
        return 3'(v % NREQ);
    endfunction

    // One-hot acknowledge vector for a client index.
    function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
        logic [NREQ-1:0] o;
        o = '0;
        for (int i = 0; i < NREQ; i++) begin
            o[i] = (idx == 3'(i));
        end
        return o;
    endfunction

`ifdef LINK_ARB_FIXED_PRIO_EN

    // Fixed priority: the lowest-numbered requesting client wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

`else

    logic [2:0]      rr_ptr;
    logic [NREQ-1:0] req_rot;

    // Round-robin: rotate the request vector so rr_ptr lands on bit 0, take
    // the first set bit, then map it back to the real client number.
    always_comb begin
        req_rot   = NREQ'({req, req} >> rr_ptr);
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(int'(rr_ptr) + i);
            end
        end
    end

    // Advance the search start to just past each winner at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 3'd0;
        end else if (state == IDLE && win_found) begin
            rr_ptr <= wrap_idx(int'(win_idx) + 1);
        end
    end

`endif

    // Only the winner's address and data are routed towards the link.
    always_comb begin
        win_addr = 2'd0;
        win_data = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 3'(i)) begin
                win_addr = req_addr[2*i +: 2];
                win_data = req_data[4*i +: 4];
            end
        end
    end

    // Control FSM with the gap counter and the registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state <= SEND;
                        busy  <= 1'b1;
                    end
                end
                SEND: begin
                    gap_cnt <= GAP_LOAD;
                    if (GAP_LOAD == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    // Counter reaches zero on the same edge that returns to IDLE.
                    if (gap_cnt <= CNT_ONE) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gap_cnt <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Capture the winning client's frame contents at grant; held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            taddr    <= 2'd0;
            tdata    <= 4'd0;
            grant_id <= 3'd0;
        end else if (state == IDLE && win_found) begin
            taddr    <= win_addr;
            tdata    <= win_data;
            grant_id <= win_idx;
        end
    end

    // Single-cycle send/ack pulses leaving SEND, plus the frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            send        <= 1'b0;
            ack         <= '0;
            frames_sent <= 8'd0;
        end else if (state == SEND) begin
            send        <= 1'b1;
            ack         <= onehot(grant_id);
            frames_sent <= frames_sent + 8'd1;
        end else begin
            send        <= 1'b0;
            ack         <= '0;
        end
    end

endmodule

// File: tb/tb_link_write_arbiter.sv
// Testbench for link_write_arbiter: table of single-grant vectors plus
// hand-written sequences for round-robin spacing, reset in GAP and counter wrap.

module tb_link_write_arbiter;

    localparam int NREQ    = 4;
    localparam int GAP_CYC = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [2*NREQ-1:0] req_addr = '0;
    logic [4*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   ack;
    logic              send;
    logic [1:0]        taddr;
    logic [3:0]        tdata;
    logic              busy;
    logic [2:0]        grant_id;
    logic [7:0]        frames_sent;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    link_write_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .ack         (ack),
        .send        (send),
        .taddr       (taddr),
        .tdata       (tdata),
        .busy        (busy),
        .grant_id    (grant_id),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NREQ-1:0]   rq;
        logic [2*NREQ-1:0] addr;
        logic [4*NREQ-1:0] data;
        int                win_rr;
        int                win_fp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_send(input int budget, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (send === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL send_timeout: no send within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_send"},     send,        0);
        chk({tag, "_ack"},      ack,         0);
        chk({tag, "_taddr"},    taddr,       0);
        chk({tag, "_tdata"},    tdata,       0);
        chk({tag, "_busy"},     busy,        0);
        chk({tag, "_grant_id"}, grant_id,    0);
        chk({tag, "_frames"},   frames_sent, 0);
    endtask

    initial begin
        int  w;
        int  exp_frames;
        int  prev_cyc;
        int  order[5];
        bit  seen;
        logic [7:0]  tmp_a;
        logic [15:0] tmp_d;

        // {req, addr bus {c3,c2,c1,c0}, data bus {c3,c2,c1,c0}, rr winner, fixed winner}
        vecs[0] = '{4'b0100, 8'h30, 16'h0A00, 2, 2};
        vecs[1] = '{4'b1010, 8'h84, 16'hC050, 3, 1};
        vecs[2] = '{4'b1010, 8'h84, 16'hC050, 1, 1};
        vecs[3] = '{4'b0011, 8'h09, 16'h007F, 0, 0};
        vecs[4] = '{4'b1111, 8'hE4, 16'h9630, 1, 0};
        vecs[5] = '{4'b0001, 8'h03, 16'h0005, 0, 0};
        vecs[6] = '{4'b1100, 8'hF0, 16'h2100, 2, 2};

        do_reset();
        chk_reset_outputs("reset");

        // Table-driven single grants from IDLE.
        exp_frames = 0;
        for (int v = 0; v < 7; v++) begin
`ifdef LINK_ARB_FIXED_PRIO_EN
            w = vecs[v].win_fp;
`else
            w = vecs[v].win_rr;
`endif
            tmp_a = vecs[v].addr >> (2 * w);
            tmp_d = vecs[v].data >> (4 * w);
            exp_frames++;
            @(negedge clk);
            req      = vecs[v].rq;
            req_addr = vecs[v].addr;
            req_data = vecs[v].data;
            @(negedge clk);
            chk($sformatf("v%0d_send_early", v), send, 0);
            chk($sformatf("v%0d_busy_send", v), busy, 1);
            @(negedge clk);
            chk($sformatf("v%0d_send", v), send, 1);
            chk($sformatf("v%0d_ack", v), ack, 32'(1) << w);
            chk($sformatf("v%0d_taddr", v), taddr, tmp_a[1:0]);
            chk($sformatf("v%0d_tdata", v), tdata, tmp_d[3:0]);
            chk($sformatf("v%0d_grant_id", v), grant_id, w);
            chk($sformatf("v%0d_frames", v), frames_sent, exp_frames);
            chk($sformatf("v%0d_busy", v), busy, 1);
            @(negedge clk);
            chk($sformatf("v%0d_ack_pulse", v), ack, 0);
            chk($sformatf("v%0d_send_pulse", v), send, 0);
            req = '0;
            repeat (GAP_CYC) @(negedge clk);
            chk($sformatf("v%0d_idle", v), busy, 0);
        end

        // Continuous requests: grant order and exact spacing.
        do_reset();
        req_addr = 8'hE4;
        req_data = 16'h9630;
`ifdef LINK_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
        req = 4'b0101;
`else
        order = '{0, 1, 2, 3, 0};
        req = 4'b1111;
`endif
        prev_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            wait_send(20, seen);
            if (seen) begin
                chk($sformatf("rr%0d_grant_id", g), grant_id, order[g]);
                chk($sformatf("rr%0d_ack", g), ack, 32'(1) << order[g]);
                chk($sformatf("rr%0d_taddr", g), taddr, order[g]);
                chk($sformatf("rr%0d_tdata", g), tdata, 3 * order[g]);
                if (g > 0) chk($sformatf("rr%0d_spacing", g), cyc - prev_cyc, GAP_CYC);
                prev_cyc = cyc;
            end
        end
        @(negedge clk);
        req = '0;
        repeat (GAP_CYC + 2) @(negedge clk);

        // Reset during GAP: frame state cleared, pointer back to 0.
        do_reset();
        @(negedge clk);
        req      = 4'b0100;
        req_addr = 8'h10;
        req_data = 16'h0300;
        wait_send(6, seen);
        req      = 4'b1010;
        req_addr = 8'h84;
        req_data = 16'hC050;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("gaprst");
        rst = 1'b0;
        @(negedge clk);
        chk("gaprst_send_early", send, 0);
        @(negedge clk);
        chk("gaprst_send", send, 1);
        chk("gaprst_ack", ack, 4'b0010);
        chk("gaprst_grant_id", grant_id, 1);
        chk("gaprst_taddr", taddr, 1);
        chk("gaprst_tdata", tdata, 5);
        chk("gaprst_frames", frames_sent, 1);
        @(negedge clk);
        req = '0;
        repeat (GAP_CYC + 2) @(negedge clk);

        // frames_sent wraps after 256 grants.
        do_reset();
        @(negedge clk);
        req      = 4'b0001;
        req_addr = 8'h01;
        req_data = 16'h0001;
        for (int i = 0; i < 256; i++) begin
            wait_send(12, seen);
            if (i == 0)   chk("wrap_first", frames_sent, 1);
            if (i == 254) chk("wrap_255", frames_sent, 255);
            if (i == 255) chk("wrap_zero", frames_sent, 0);
        end
        @(negedge clk);
        req = '0;
        repeat (GAP_CYC + 2) @(negedge clk);
        chk("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
